// File: rtl/c2c_tx_arbiter.sv
// Round-robin arbiter that merges four FWFT source FIFOs into one registered
// TX beat stream. A packet is never interleaved, and a packet is cut at MAX_BEATS.
module c2c_tx_arbiter #(
    parameter int unsigned DATA_BITS = 578,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned CNT_BITS  = 5
) (
    input  logic                   AURORA_CLK,
    input  logic                   AURORA_RESET,
    input  logic                   CH_UP,
    input  logic [3:0]             SRC_EMPTY,
    output logic [3:0]             SRC_RDEN,
    input  logic [4*DATA_BITS-1:0] SRC_RDATA,
    input  logic [3:0]             SRC_RLAST,
    output logic [DATA_BITS-1:0]   TX_TDATA,
    output logic [1:0]             TX_TID,
    output logic                   TX_TLAST,
    output logic                   TX_TVALID,
    input  logic                   TX_TREADY,
    output logic [3:0]             GRANT,
    output logic                   OVERLEN_ERR
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]           state_q,    state_d;
    logic [1:0]           rr_ptr_q,   rr_ptr_d;
    logic [1:0]           gidx_q,     gidx_d;
    logic [3:0]           grant_q,    grant_d;
    logic [CNT_BITS-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DATA_BITS-1:0] tdata_q,    tdata_d;
    logic [1:0]           tid_q,      tid_d;
    logic                 tlast_q,    tlast_d;
    logic                 tvalid_q,   tvalid_d;
    logic                 overlen_q,  overlen_d;

    logic                 ld_c;
    logic                 last_c;
    logic                 cnt_max_c;
    logic                 any_req_c;
    logic [1:0]           sel_c;
    logic [DATA_BITS-1:0] head_data_c;

    // First non-empty source searching upward from the round-robin pointer
    always_comb begin : rr_search
        logic       found;
        logic [1:0] idx;
        found = 1'b0;
        idx   = rr_ptr_q;
        sel_c = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && !SRC_EMPTY[idx]) begin
                sel_c = idx;
                found = 1'b1;
            end
        end
    end

    // Head word of the granted source
    always_comb begin : head_mux
        head_data_c = '0;
        for (int i = 0; i < 4; i++) begin
            if (gidx_q == 2'(i)) begin
                head_data_c = SRC_RDATA[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Pop/load qualifier; reset suppresses any pop in the same cycle
    always_comb begin : load_ctrl
        any_req_c = ~&SRC_EMPTY;
        ld_c      = (state_q == ST_XFER) && !SRC_EMPTY[gidx_q] &&
                    (!tvalid_q || TX_TREADY) && !AURORA_RESET;
        cnt_max_c = (beat_cnt_q == CNT_BITS'(MAX_BEATS - 1));
        last_c    = SRC_RLAST[gidx_q] | cnt_max_c;
        SRC_RDEN  = ld_c ? (4'b0001 << gidx_q) : 4'b0000;
    end

    // Next-state and output-register logic
    always_comb begin : next_state
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gidx_d     = gidx_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        tdata_d    = tdata_q;
        tid_d      = tid_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        overlen_d  = overlen_q;

        if (ld_c) begin
            tdata_d    = head_data_c;
            tid_d      = gidx_q;
            tlast_d    = last_c;
            tvalid_d   = 1'b1;
            beat_cnt_d = beat_cnt_q + CNT_BITS'(1);
            if (cnt_max_c && !SRC_RLAST[gidx_q]) begin
                overlen_d = 1'b1;
            end
        end else if (TX_TREADY) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                grant_d = 4'b0000;
                if (CH_UP && any_req_c) begin
                    gidx_d     = sel_c;
                    grant_d    = 4'b0001 << sel_c;
                    beat_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                // Packet end: release the grant and rotate priority past this source
                if (ld_c && last_c) begin
                    rr_ptr_d = gidx_q + 2'd1;
                    grant_d  = 4'b0000;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge AURORA_CLK) begin
        if (AURORA_RESET) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 2'd0;
            gidx_q     <= 2'd0;
            grant_q    <= 4'b0000;
            beat_cnt_q <= '0;
            tdata_q    <= '0;
            tid_q      <= 2'd0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            overlen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            tdata_q    <= tdata_d;
            tid_q      <= tid_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            overlen_q  <= overlen_d;
        end
    end

    assign TX_TDATA    = tdata_q;
    assign TX_TID      = tid_q;
    assign TX_TLAST    = tlast_q;
    assign TX_TVALID   = tvalid_q;
    assign GRANT       = grant_q;
    assign OVERLEN_ERR = overlen_q;

endmodule

// File: tb/tb_c2c_tx_arbiter.sv
// Bench for c2c_tx_arbiter: source FIFO models feed the DUT, every pop pushes
// the expected TX beat to a scoreboard, and every accepted beat pops and compares.
module tb_c2c_tx_arbiter;

    localparam int unsigned DW = 578;
    localparam int unsigned MB = 16;
    localparam int unsigned CB = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } ent_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    tid;
        logic          last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            ch_up;
    logic            tready;
    logic [3:0]      src_empty;
    logic [3:0]      src_rden;
    logic [4*DW-1:0] src_rdata;
    logic [3:0]      src_rlast;
    logic [DW-1:0]   tx_tdata;
    logic [1:0]      tx_tid;
    logic            tx_tlast;
    logic            tx_tvalid;
    logic [3:0]      grant;
    logic            overlen_err;

    always #5 clk = ~clk;

    c2c_tx_arbiter #(.DATA_BITS(DW), .MAX_BEATS(MB), .CNT_BITS(CB)) dut (
        .AURORA_CLK  (clk),
        .AURORA_RESET(rst),
        .CH_UP       (ch_up),
        .SRC_EMPTY   (src_empty),
        .SRC_RDEN    (src_rden),
        .SRC_RDATA   (src_rdata),
        .SRC_RLAST   (src_rlast),
        .TX_TDATA    (tx_tdata),
        .TX_TID      (tx_tid),
        .TX_TLAST    (tx_tlast),
        .TX_TVALID   (tx_tvalid),
        .TX_TREADY   (tready),
        .GRANT       (grant),
        .OVERLEN_ERR (overlen_err)
    );

    int            passed = 0;
    int            total  = 0;
    ent_t          src_q [4][$];
    exp_t          sb [$];
    logic [3:0]    pend = 4'b0000;
    int            mcnt = 0;
    logic [1:0]    obs_tid [$];
    logic          obs_last [$];
    logic [DW-1:0] obs_data [$];
    int            rden_cnt [4];
    int            run_len = 0;
    int            max_run = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_tid;
    logic          prev_last;

    function automatic logic [DW-1:0] mk(int s, int n);
        logic [DW-1:0] d;
        d = '0;
        d[31:0]       = $urandom;
        d[300 +: 32]  = $urandom;
        d[DW-1 -: 16] = 16'(s * 256 + n);
        return d;
    endfunction

    task automatic push_pkt(input int s, input int n, input int last_at);
        ent_t e;
        for (int k = 1; k <= n; k++) begin
            e.data = mk(s, k);
            e.last = (k == last_at);
            src_q[s].push_back(e);
        end
    endtask

    task automatic clr_obs();
        obs_tid.delete();
        obs_last.delete();
        obs_data.delete();
        for (int i = 0; i < 4; i++) rden_cnt[i] = 0;
        max_run = 0;
        run_len = 0;
    endtask

    // One clock: apply last pops, drive sources, monitor, then advance to next negedge
    task automatic cycle();
        exp_t x;
        ent_t e;
        for (int i = 0; i < 4; i++) begin
            if (pend[i] && src_q[i].size() > 0) src_q[i].delete(0);
        end
        pend = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            src_empty[i] = (src_q[i].size() == 0);
            src_rdata[i*DW +: DW] = src_empty[i] ? '0 : src_q[i][0].data;
            src_rlast[i] = src_empty[i] ? 1'b0 : src_q[i][0].last;
        end
        #1;
        if (rst) begin
            total++;
            if (src_rden !== 4'b0000) $display("FAIL rden_in_reset: got %b want 0000", src_rden);
            else passed++;
        end else if (src_rden !== 4'b0000) begin
            total++;
            if (!$onehot(src_rden) || (src_rden & src_empty) != 4'b0000)
                $display("FAIL rden_legal: rden %b empty %b", src_rden, src_empty);
            else passed++;
            for (int i = 0; i < 4; i++) begin
                if (src_rden[i] && src_q[i].size() > 0) begin
                    e      = src_q[i][0];
                    x.data = e.data;
                    x.tid  = 2'(i);
                    x.last = e.last | (mcnt == int'(MB) - 1);
                    mcnt   = x.last ? 0 : mcnt + 1;
                    sb.push_back(x);
                    pend[i] = 1'b1;
                    rden_cnt[i]++;
                end
            end
        end
        if (prev_hold && !rst) begin
            total++;
            if (tx_tvalid !== 1'b1 || tx_tdata !== prev_data || tx_tid !== prev_tid || tx_tlast !== prev_last)
                $display("FAIL hold_stable: valid %b tid %0d last %b tag %h want valid 1 tid %0d last %b tag %h",
                         tx_tvalid, tx_tid, tx_tlast, tx_tdata[DW-1 -: 16], prev_tid, prev_last, prev_data[DW-1 -: 16]);
            else passed++;
        end
        if (!rst && tx_tvalid === 1'b1 && tready) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: tid %0d tag %h with no pending expectation", tx_tid, tx_tdata[DW-1 -: 16]);
            end else begin
                x = sb.pop_front();
                if (tx_tdata !== x.data || tx_tid !== x.tid || tx_tlast !== x.last)
                    $display("FAIL sb_beat: got tid %0d last %b tag %h lo %h want tid %0d last %b tag %h lo %h",
                             tx_tid, tx_tlast, tx_tdata[DW-1 -: 16], tx_tdata[31:0],
                             x.tid, x.last, x.data[DW-1 -: 16], x.data[31:0]);
                else passed++;
            end
            obs_tid.push_back(tx_tid);
            obs_last.push_back(tx_tlast);
            obs_data.push_back(tx_tdata);
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        prev_hold = !rst && tx_tvalid === 1'b1 && !tready;
        prev_data = tx_tdata;
        prev_tid  = tx_tid;
        prev_last = tx_tlast;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        sb.delete();
        mcnt = 0;
        prev_hold = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int  n;
        bool_busy: begin end
        n = 0;
        while (n < max_cyc && (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() != 0 ||
                               sb.size() != 0 || tx_tvalid !== 1'b0 || pend != 4'b0000)) begin
            cycle();
            n++;
        end
        total++;
        if (n >= max_cyc) $display("FAIL drain_timeout: %0d cycles, sb %0d pending", n, sb.size());
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_up = 1'b0; tready = 1'b1; src_empty = 4'hF;
        src_rdata = '0; src_rlast = 4'h0;
        repeat (3) cycle();
        total++; if (grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", grant); else passed++;
        total++; if (tx_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", tx_tvalid); else passed++;
        total++; if (tx_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", tx_tlast); else passed++;
        total++; if (tx_tid !== 2'd0) $display("FAIL rst_tid: got %0d want 0", tx_tid); else passed++;
        total++; if (tx_tdata !== '0) $display("FAIL rst_tdata: got tag %h want 0", tx_tdata[DW-1 -: 16]); else passed++;
        total++; if (overlen_err !== 1'b0) $display("FAIL rst_overlen: got %b want 0", overlen_err); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        clr_obs();
        ch_up = 1'b1; tready = 1'b1;
        push_pkt(2, 1, 1);
        cycle();
        total++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b want 0100", grant); else passed++;
        cycle();
        total++; if (tx_tvalid !== 1'b1 || tx_tid !== 2'd2 || tx_tlast !== 1'b1)
            $display("FAIL single_beat: valid %b tid %0d last %b want 1 2 1", tx_tvalid, tx_tid, tx_tlast);
        else passed++;
        total++; if (grant !== 4'b0000) $display("FAIL single_release: got %b want 0000", grant); else passed++;
        cycle();
        total++; if (tx_tvalid !== 1'b0) $display("FAIL single_valid_drop: got %b want 0", tx_tvalid); else passed++;
        total++; if (rden_cnt[2] != 1) $display("FAIL single_pops: got %0d want 1", rden_cnt[2]); else passed++;
        // Pointer now at 3: source 3 must win over source 0
        clr_obs();
        push_pkt(0, 1, 1);
        push_pkt(3, 1, 1);
        drain(40);
        total++; if (obs_tid.size() != 2 || obs_tid[0] !== 2'd3 || obs_tid[1] !== 2'd0)
            $display("FAIL single_rr_next: got %0d beats first tid %0d want 2 beats 3 then 0",
                     obs_tid.size(), obs_tid.size() > 0 ? obs_tid[0] : 2'd0);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_tid;
        logic       exp_last;
        do_reset();
        clr_obs();
        ch_up = 1'b1; tready = 1'b1;
        for (int s = 0; s < 4; s++) push_pkt(s, 2, 2);
        drain(80);
        for (int k = 0; k < 8; k++) begin
            exp_tid  = 2'(k / 2);
            exp_last = (k % 2 == 1);
            total++;
            if (k >= obs_tid.size() || obs_tid[k] !== exp_tid || obs_last[k] !== exp_last)
                $display("FAIL rr_order[%0d]: got tid %0d last %b want tid %0d last %b", k,
                         k < obs_tid.size() ? obs_tid[k] : 2'd0, k < obs_last.size() ? obs_last[k] : 1'b0,
                         exp_tid, exp_last);
            else passed++;
        end
        total++; if (overlen_err !== 1'b0) $display("FAIL rr_overlen: got %b want 0", overlen_err); else passed++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] sent [$];
        logic [DW-1:0] held;
        int            pops0;
        int            n;
        int            bad;
        do_reset();
        clr_obs();
        ch_up = 1'b1; tready = 1'b1;
        push_pkt(1, 6, 6);
        foreach (src_q[1][k]) sent.push_back(src_q[1][k].data);
        n = 0;
        while (obs_data.size() < 2 && n < 30) begin cycle(); n++; end
        tready = 1'b0;
        held  = tx_tdata;
        pops0 = rden_cnt[1];
        repeat (5) cycle();
        total++; if (rden_cnt[1] != pops0) $display("FAIL bp_no_pop: got %0d pops want 0", rden_cnt[1] - pops0); else passed++;
        total++; if (tx_tvalid !== 1'b1 || tx_tdata !== held)
            $display("FAIL bp_held: valid %b tag %h want 1 tag %h", tx_tvalid, tx_tdata[DW-1 -: 16], held[DW-1 -: 16]);
        else passed++;
        tready = 1'b1;
        drain(40);
        bad = 0;
        for (int k = 0; k < 6; k++) if (k >= obs_data.size() || obs_data[k] !== sent[k]) bad++;
        total++; if (obs_data.size() != 6 || bad != 0)
            $display("FAIL bp_sequence: got %0d beats %0d wrong want 6 beats 0 wrong", obs_data.size(), bad);
        else passed++;
    endtask

    task automatic test_forced_tlast();
        int nlast;
        do_reset();
        clr_obs();
        ch_up = 1'b1; tready = 1'b1;
        push_pkt(1, 20, 20);
        drain(100);
        nlast = 0;
        foreach (obs_last[k]) if (obs_last[k]) nlast++;
        total++; if (obs_last.size() != 20) $display("FAIL force_count: got %0d beats want 20", obs_last.size()); else passed++;
        total++; if (obs_last.size() < 20 || obs_last[15] !== 1'b1 || obs_last[19] !== 1'b1 || nlast != 2)
            $display("FAIL force_tlast: got %0d TLAST beats want 2 at beats 16 and 20", nlast);
        else passed++;
        total++; if (overlen_err !== 1'b1) $display("FAIL force_overlen: got %b want 1", overlen_err); else passed++;
        total++; if (max_run != 16) $display("FAIL force_run: got longest run %0d want 16", max_run); else passed++;
    endtask

    task automatic test_link_gating();
        do_reset();
        clr_obs();
        ch_up = 1'b0; tready = 1'b1;
        push_pkt(3, 2, 2);
        repeat (6) cycle();
        total++; if (grant !== 4'b0000 || tx_tvalid !== 1'b0 || src_q[3].size() != 2)
            $display("FAIL link_gated: grant %b valid %b left %0d want 0000 0 2", grant, tx_tvalid, src_q[3].size());
        else passed++;
        ch_up = 1'b1;
        cycle();
        total++; if (grant !== 4'b1000) $display("FAIL link_grant: got %b want 1000", grant); else passed++;
        ch_up = 1'b0;
        drain(40);
        total++; if (obs_last.size() != 2 || obs_last[1] !== 1'b1 || obs_tid[0] !== 2'd3)
            $display("FAIL link_complete: got %0d beats want 2 from source 3", obs_last.size());
        else passed++;
    endtask

    task automatic test_reset_mid_packet();
        int n;
        ch_up = 1'b1; tready = 1'b1;
        clr_obs();
        push_pkt(1, 1, 1);
        drain(40);
        clr_obs();
        push_pkt(2, 8, 8);
        push_pkt(0, 1, 1);
        n = 0;
        while (obs_data.size() < 2 && n < 30) begin cycle(); n++; end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        mcnt = 0;
        prev_hold = 1'b0;
        total++; if (grant !== 4'b0000 || tx_tvalid !== 1'b0 || tx_tlast !== 1'b0 || tx_tid !== 2'd0 || tx_tdata !== '0)
            $display("FAIL midrst_outputs: grant %b valid %b last %b tid %0d want all zero", grant, tx_tvalid, tx_tlast, tx_tid);
        else passed++;
        clr_obs();
        drain(60);
        total++; if (obs_tid.size() == 0 || obs_tid[0] !== 2'd0)
            $display("FAIL midrst_restart: first tid %0d want 0", obs_tid.size() > 0 ? obs_tid[0] : 2'd3);
        else passed++;
        total++; if (obs_tid.size() < 2 || obs_tid[obs_tid.size()-1] !== 2'd2 || obs_last[obs_last.size()-1] !== 1'b1)
            $display("FAIL midrst_resume: remainder of source 2 not completed, %0d beats seen", obs_tid.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_round_robin();
        test_backpressure();
        test_forced_tlast();
        test_link_gating();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
